// File: rtl/fetch_unit_if.sv
// Fetch-stage handshakes: imem request/response, branch redirect, decode output.
// master = fetch unit side, slave = memory/decode/branch-resolution side.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_plus4;

  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, dec_pc_plus4,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, dec_pc_plus4,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: in-order imem requests, DEPTH-entry return queue, 1-cycle response-to-decode latency;
// stalls requests when DEPTH are allocated. FETCH_BYPASS_EN adds a same-cycle empty-queue bypass.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  localparam int            AW       = $clog2(DEPTH);
  localparam int            PW       = AW + 1;
  localparam int            DW       = 16;
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [PW-1:0] alloc_ptr, fill_ptr, head_ptr;
  logic [PW-1:0] alloc_nxt, fill_nxt, head_nxt, head_hs, in_flight;
  logic [DW-1:0] drop_cnt, drop_nxt;
  logic          boot;
  logic [31:0]   pc_q    [DEPTH];
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   dec_instr_r, dec_pc_r;
  logic          full, req_acc, rsp_keep, rsp_drop, queued, dec_hs;

  assign full      = (alloc_ptr - head_ptr) == FULL_CNT;
  assign in_flight = alloc_ptr - fill_ptr;

  assign bus.imem_req_valid = !boot && !full;
  assign bus.imem_req_addr  = fetch_pc;

  assign req_acc  = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_drop = bus.imem_rsp_valid && (drop_cnt != '0);
  assign rsp_keep = bus.imem_rsp_valid && (drop_cnt == '0);
  assign queued   = fill_ptr != head_ptr;

`ifdef FETCH_BYPASS_EN
  logic byp;
  // An empty queue lets a kept response go straight to decode; its pc was stored at allocation.
  assign byp           = !queued && rsp_keep;
  assign bus.dec_valid = queued || byp;
  assign bus.dec_instr = byp ? bus.imem_rsp_data : dec_instr_r;
  assign bus.dec_pc    = byp ? pc_q[fill_ptr[AW-1:0]] : dec_pc_r;
`else
  assign bus.dec_valid = queued;
  assign bus.dec_instr = dec_instr_r;
  assign bus.dec_pc    = dec_pc_r;
`endif

  assign bus.dec_pc_plus4 = bus.dec_pc + 32'd4;

  assign dec_hs  = bus.dec_valid && bus.dec_ready;
  assign head_hs = head_ptr + PW'(dec_hs);

  always_comb begin
    alloc_nxt = alloc_ptr + PW'(req_acc);
    fill_nxt  = fill_ptr + PW'(rsp_keep);
    head_nxt  = head_hs;
    drop_nxt  = drop_cnt - DW'(rsp_drop);
    if (bus.redirect_valid) begin
      // Everything still owed by memory (old drops, unfilled slots, this cycle's accept) gets discarded.
      alloc_nxt = head_hs;
      fill_nxt  = head_hs;
      drop_nxt  = drop_cnt + DW'(in_flight) + DW'(req_acc) - DW'(bus.imem_rsp_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      drop_cnt    <= '0;
      boot        <= 1'b1;
      dec_instr_r <= '0;
      dec_pc_r    <= RESET_PC;
    end else begin
      boot      <= 1'b0;
      alloc_ptr <= alloc_nxt;
      fill_ptr  <= fill_nxt;
      head_ptr  <= head_nxt;
      drop_cnt  <= drop_nxt;
      if (bus.redirect_valid) begin
        fetch_pc <= bus.redirect_pc & 32'hFFFF_FFFC;
      end else if (req_acc) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      // Present the next head entry, forwarding a word landing in that slot this cycle.
      if (rsp_keep && (fill_ptr[AW-1:0] == head_nxt[AW-1:0])) begin
        dec_instr_r <= bus.imem_rsp_data;
      end else begin
        dec_instr_r <= instr_q[head_nxt[AW-1:0]];
      end
      dec_pc_r <= pc_q[head_nxt[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (req_acc) begin
      pc_q[alloc_ptr[AW-1:0]] <= fetch_pc;
    end
    if (rsp_keep) begin
      instr_q[fill_ptr[AW-1:0]] <= bus.imem_rsp_data;
    end
  end
endmodule
